// File: rtl/rom_pkg.sv
// rom_pkg -- shared widths, constant contents and lookup helper for the rom block.
// Revision: 1.0
`default_nettype none

package rom_pkg;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 4;
  localparam int ROM_DEPTH  = 2 ** ROM_ADDR_W;

  localparam logic [ROM_DATA_W-1:0] ROM_TABLE [ROM_DEPTH] = '{
    4'h5, 4'h9, 4'hC, 4'h1, 4'h6, 4'hF, 4'h3, 4'hA
  };

  function automatic logic [ROM_DATA_W-1:0] rom_lookup(input logic [ROM_ADDR_W-1:0] addr);
    return ROM_TABLE[addr];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_table.sv
// rom_table -- purely combinational decode of the constant contents.
// Revision: 1.0
`default_nettype none

module rom_table
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Contents exist for the default depth only; any other address decodes to zero.
  always_comb begin
    data = '0;
    case (addr)
      ADDR_W'(0): data = DATA_W'(ROM_TABLE[0]);
      ADDR_W'(1): data = DATA_W'(ROM_TABLE[1]);
      ADDR_W'(2): data = DATA_W'(ROM_TABLE[2]);
      ADDR_W'(3): data = DATA_W'(ROM_TABLE[3]);
      ADDR_W'(4): data = DATA_W'(ROM_TABLE[4]);
      ADDR_W'(5): data = DATA_W'(ROM_TABLE[5]);
      ADDR_W'(6): data = DATA_W'(ROM_TABLE[6]);
      ADDR_W'(7): data = DATA_W'(ROM_TABLE[7]);
      default:    data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rom.sv
// rom -- 8x4 constant lookup table with a registered, enable-qualified read port.
// Revision: 1.0
`default_nettype none

module rom
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ROM_en,
  input  logic [ADDR_W-1:0] ROM_adr,
  output logic [DATA_W-1:0] ROM_data,
  output logic              ROM_valid
);

  logic [DATA_W-1:0] table_data;

  rom_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_table (
    .addr (ROM_adr),
    .data (table_data)
  );

  // Data only moves on an accepted read; idle cycles drop valid but keep the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ROM_data  <= '0;
      ROM_valid <= 1'b0;
    end else if (ROM_en) begin
      ROM_data  <= $isunknown(ROM_adr) ? '0 : table_data;
      ROM_valid <= 1'b1;
    end else begin
      ROM_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && ROM_en && $isunknown(ROM_adr))
      $error("rom: read with unknown address %b", ROM_adr);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom.sv
// tb_rom -- randomized and directed checks of rom against a behavioural model.
// Revision: 1.0
`default_nettype none

module tb_rom;
  import rom_pkg::*;

  logic       clk;
  logic       rst;
  logic       ROM_en;
  logic [2:0] ROM_adr;
  logic [3:0] ROM_data;
  logic       ROM_valid;

  int checks   = 0;
  int failures = 0;

  // Reference contents written straight from the published table.
  logic [3:0] ref_tbl [8] = '{4'h5, 4'h9, 4'hC, 4'h1, 4'h6, 4'hF, 4'h3, 4'hA};
  logic [3:0] exp_data  = 4'h0;
  logic       exp_valid = 1'b0;

  rom dut (
    .clk       (clk),
    .rst       (rst),
    .ROM_en    (ROM_en),
    .ROM_adr   (ROM_adr),
    .ROM_data  (ROM_data),
    .ROM_valid (ROM_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs mid-cycle, let the edge happen, update the model, then compare.
  task automatic cyc(input logic r, input logic e, input logic [2:0] a, input string tag);
    @(negedge clk);
    rst     = r;
    ROM_en  = e;
    ROM_adr = a;
    @(posedge clk);
    if (r) begin
      exp_data  = 4'h0;
      exp_valid = 1'b0;
    end else if (e) begin
      exp_data  = $isunknown(a) ? 4'h0 : ref_tbl[a];
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check({tag, "_data"},  {28'h0, ROM_data},  {28'h0, exp_data});
    check({tag, "_valid"}, {31'h0, ROM_valid}, {31'h0, exp_valid});
  endtask

  initial begin
    logic [2:0] xadr;
    rst = 1'b1; ROM_en = 1'b1; ROM_adr = 3'd0;

    // Reset held with enable high
    cyc(1'b1, 1'b1, 3'd4, "reset0");
    cyc(1'b1, 1'b1, 3'd5, "reset1");

    // Descending sweep directly after reset release
    for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, 3'(i), "desc");

    // Hold: idle cycles keep F while the address moves
    cyc(1'b0, 1'b1, 3'd5, "hold_rd");
    check("hold_rd_F", {28'h0, ROM_data}, 32'hF);
    cyc(1'b0, 1'b0, 3'd2, "hold_idle0");
    cyc(1'b0, 1'b0, 3'd7, "hold_idle1");
    check("hold_keep_F", {28'h0, ROM_data}, 32'hF);

    // Reset in the middle of a read stream
    cyc(1'b0, 1'b1, 3'd3, "mid_rd");
    cyc(1'b1, 1'b1, 3'd3, "mid_rst");
    cyc(1'b0, 1'b1, 3'd6, "mid_after");
    check("mid_after_3", {28'h0, ROM_data}, 32'h3);

    // Ascending full-rate sweep, also cross-checking the package helper
    for (int i = 0; i < 8; i++) begin
      check("pkg_lookup", {28'h0, rom_lookup(3'(i))}, {28'h0, ref_tbl[i]});
      cyc(1'b0, 1'b1, 3'(i), "asc");
    end

    // Randomized traffic with occasional resets and idle cycles
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), "rand");
    end

    // Unknown address: model predicts zero whenever the driven value is unknown
    xadr = 3'bxxx;
    cyc(1'b0, 1'b1, 3'd1, "x_pre");
    cyc(1'b0, 1'b1, xadr, "x_adr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
